exibe_sequencia_ctrl: RTL
=========================

# exibe_sequencia_ctrl

Controller that plays back the stored move sequence before each round of the memory game. On a start request from the main control unit it walks the sequence memory from address 0 up to the current round index. For each entry it lights the stored LED pattern for a fixed ON time, then blanks the LEDs for a fixed OFF time, and finally pulses a completion flag. It drives the memory address and the LED outputs, and it owns its own address counter and interval timer.

## Interface
Parameters:
- T_ON, default 500: clock cycles each entry is lit. Legal range 1..65535.
- T_OFF, default 250: clock cycles of blank gap after each entry. Legal range 1..65535.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces state ocioso.
- iniciar  in  1  start request; sampled only in ocioso.
- cancelar  in  1  abort; has priority over everything except reset.
- rodada  in  4  index of the last entry to show (0..15); latched at start.
- dado_memoria  in  4  read data from the sequence memory (combinational read of endereco).
- endereco  out  4  sequence memory address.
- leds  out  4  LED pattern being shown.
- exibindo  out  1  high while playback is in progress.
- fim_exibicao  out  1  one-cycle pulse when playback completes.
- db_estado  out  3  debug state code.

## Operation
- States and db_estado codes: ocioso=0, carrega=1, acende=2, apaga=3, avanca=4, fim=5. An unused code goes to ocioso next cycle, and db_estado shows 7 while the FSM is in that code.
- ocioso:
  - Outputs: endereco=0, leds=0, exibindo=0.
  - If iniciar=1: latch rodada into rodada_reg, clear the address counter, and go to carrega.
- carrega:
  - Latch dado_memoria into leds_reg and clear the timer.
  - Go to acende.
- acende:
  - leds=leds_reg; the timer increments each cycle.
  - When timer==T_ON-1: clear the timer and go to apaga.
- apaga:
  - leds=0; the timer increments each cycle.
  - When timer==T_OFF-1: go to fim if endereco==rodada_reg, otherwise go to avanca.
- avanca:
  - endereco increments by 1 and the FSM goes to carrega.
  - endereco never wraps, because the FSM stops at rodada_reg ≤ 15.
- fim:
  - fim_exibicao=1 and exibindo=0.
  - Go to ocioso unconditionally.
- exibindo=1 in carrega, acende, apaga and avanca.
- endereco holds the counter value in every state except ocioso.
- cancelar=1 in any state:
  - Next state is ocioso. leds goes to 0 from that cycle on, and the address counter and timer clear.
  - No fim_exibicao pulse is produced.
- iniciar is ignored outside ocioso. A change on rodada during playback has no effect.
- The timer is 16 bits wide and is compared with ==, never with an overflow check.
- All outputs are Moore outputs decoded from the state and registers, and are glitch-free at the register level.

## Timing
- Reset values: state=ocioso, endereco=0, leds=0, exibindo=0, fim_exibicao=0, db_estado=0, rodada_reg=0, timer=0.
- Start latency: with iniciar high at edge k, the FSM enters carrega at k and leds shows data at k+1.
- Per entry:
  - carrega lasts 1 cycle.
  - leds is nonzero-capable for exactly T_ON cycles and then 0 for exactly T_OFF cycles.
  - avanca lasts 1 cycle (omitted after the last entry).
- Playback length: with N=rodada+1 entries, exibindo is high for exactly N·(T_ON+T_OFF+2)−1 cycles, immediately followed by one fim cycle.
- A new start can be accepted at the earliest in the cycle after fim, i.e. once the FSM is back in ocioso.
- Simultaneous iniciar and cancelar in ocioso: the FSM stays in ocioso.
- Reset mid-playback: all outputs go to their reset values immediately (asynchronously).

## Test plan
- Reset, then idle: assert reset during acende, then release. leds=0, exibindo=0 and db_estado=0 immediately, and the FSM stays in ocioso with iniciar=0.
- Single entry (T_ON=3, T_OFF=2, rodada=0, mem[0]=4'b0010):
  - leds=0010 for 3 cycles, then 0 for 2 cycles.
  - exibindo is high for 6 cycles, then fim_exibicao pulses once.
  - endereco stays 0 throughout.
- Four entries (T_ON=3, T_OFF=2, rodada=3, mem=1,2,4,8):
  - endereco steps 0→1→2→3, and leds shows 1,2,4,8 in order with 2-cycle gaps.
  - exibindo is high for 27 cycles, then there is one fim pulse.
- Full depth (rodada=15): endereco reaches 15 without wrapping, followed by a single fim pulse, and the FSM returns to ocioso.
- Cancel during acende at the second entry: the FSM is in ocioso on the next cycle with leds=0 and endereco=0, and no fim pulse occurs. A subsequent start replays from address 0.
- iniciar and rodada changes during playback are ignored: pulsing iniciar and changing rodada mid-run produces the same cycle count and the same last address as an undisturbed run.

Source files
------------

// File: rtl/exibe_sequencia_ctrl.sv
// -----------------------------------------------------------------------------
// exibe_sequencia_ctrl
//
// Plays back the stored move sequence of the memory game. When iniciar is
// seen in the idle state, the controller walks the sequence memory from
// address 0 up to the latched round index. Each entry is lit for T_ON cycles
// and then blanked for T_OFF cycles. After the last entry it pulses
// fim_exibicao for one cycle and returns to idle.
//
// Parameters:
//   T_ON          cycles each entry is lit   (1..65535)
//   T_OFF         cycles of blank gap        (1..65535)
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   iniciar       start request, only honoured in idle
//   cancelar      abort, wins over everything except reset
//   rodada        index of the last entry to show, latched at start
//   dado_memoria  combinational read data for address endereco
//   endereco      sequence memory address
//   leds          LED pattern being shown
//   exibindo      high while playback is in progress
//   fim_exibicao  one-cycle pulse when playback completes
//   db_estado     debug state code (7 = illegal encoding)
// -----------------------------------------------------------------------------
module exibe_sequencia_ctrl #(
    parameter int unsigned T_ON  = 500,
    parameter int unsigned T_OFF = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic [3:0] rodada,
    input  logic [3:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       fim_exibicao,
    output logic [2:0] db_estado
);

    // Terminal counts; the timer runs 0..N-1 so a phase lasts exactly N cycles.
    localparam logic [15:0] TOnLast  = 16'(T_ON - 1);
    localparam logic [15:0] TOffLast = 16'(T_OFF - 1);

    // Encodings double as the debug codes shown on db_estado.
    typedef enum logic [2:0] {
        StOcioso  = 3'd0,
        StCarrega = 3'd1,
        StAcende  = 3'd2,
        StApaga   = 3'd3,
        StAvanca  = 3'd4,
        StFim     = 3'd5
    } estado_e;

    estado_e     estado_q, estado_d;
    logic [3:0]  endereco_q, endereco_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  leds_q, leds_d;
    logic [3:0]  rodada_q, rodada_d;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= StOcioso;
            endereco_q <= 4'd0;
            timer_q    <= 16'd0;
            leds_q     <= 4'd0;
            rodada_q   <= 4'd0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            timer_q    <= timer_d;
            leds_q     <= leds_d;
            rodada_q   <= rodada_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        timer_d    = timer_q;
        leds_d     = leds_q;
        rodada_d   = rodada_q;

        case (estado_q)
            StOcioso: begin
                if (iniciar) begin
                    rodada_d   = rodada;
                    endereco_d = 4'd0;
                    estado_d   = StCarrega;
                end
            end

            StCarrega: begin
                leds_d   = dado_memoria;
                timer_d  = 16'd0;
                estado_d = StAcende;
            end

            StAcende: begin
                if (timer_q == TOnLast) begin
                    timer_d  = 16'd0;
                    estado_d = StApaga;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            StApaga: begin
                if (timer_q == TOffLast) begin
                    timer_d  = 16'd0;
                    estado_d = (endereco_q == rodada_q) ? StFim : StAvanca;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            // Cannot wrap: the walk stops once endereco matches rodada_q <= 15.
            StAvanca: begin
                endereco_d = endereco_q + 4'd1;
                estado_d   = StCarrega;
            end

            StFim: begin
                estado_d = StOcioso;
            end

            default: begin
                estado_d   = StOcioso;
                endereco_d = 4'd0;
                timer_d    = 16'd0;
                leds_d     = 4'd0;
            end
        endcase

        // Abort overrides whatever the state decided, including a start in idle.
        if (cancelar) begin
            estado_d   = StOcioso;
            endereco_d = 4'd0;
            timer_d    = 16'd0;
            leds_d     = 4'd0;
            rodada_d   = rodada_q;
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        endereco     = endereco_q;
        leds         = 4'd0;
        exibindo     = 1'b0;
        fim_exibicao = 1'b0;
        db_estado    = estado_q;

        case (estado_q)
            StOcioso: begin
                endereco = 4'd0;
            end
            StCarrega: begin
                exibindo = 1'b1;
            end
            StAcende: begin
                leds     = leds_q;
                exibindo = 1'b1;
            end
            StApaga: begin
                exibindo = 1'b1;
            end
            StAvanca: begin
                exibindo = 1'b1;
            end
            StFim: begin
                fim_exibicao = 1'b1;
            end
            default: begin
                endereco  = 4'd0;
                db_estado = 3'd7;
            end
        endcase
    end

endmodule
